// File: rtl/border_flash_ctrl_pkg.sv
// Shared constants for the playfield border path: game-phase encoding,
// visible-area geometry and a small saturating helper for the lives count.
package border_flash_ctrl_pkg;

  // Game-phase encoding, kept as plain 2-bit constants so older blocks that
  // decode the state bus directly stay compatible.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] FLASH = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  // Visible-area geometry shared with the VGA sync and border generators.
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  // Decrement that sticks at zero instead of wrapping to 15.
  function automatic logic [3:0] sat_dec(input logic [3:0] value);
    return (value == 4'd0) ? 4'd0 : value - 4'd1;
  endfunction

endpackage

// File: rtl/border_flash_ctrl_frame_tick_gen.sv
// Produces a single-clock frame pulse when the pixel counters reach the
// first blanking line. Edge detection means a stalled counter cannot
// generate repeat pulses.
module frame_tick_gen #(
  parameter int unsigned V_ACTIVE = border_flash_ctrl_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Horizontal,
  input  logic [15:0] Vertical,
  output logic        frame_tick
);

  logic frame_cond;
  logic frame_cond_q;

  // Decode of the first pixel of the first blanking line.
  always_comb begin
    frame_cond = (Horizontal == 16'd0) && (Vertical == 16'(V_ACTIVE));
  end

  // Remember the previous condition and pulse on its rising edge only.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      frame_cond_q <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      frame_cond_q <= frame_cond;
      frame_tick   <= frame_cond & ~frame_cond_q;
    end
  end

endmodule

// File: rtl/border_flash_ctrl.sv
// Game-phase controller for the green playfield border. Gates the raw
// border flag with a per-frame visibility bit, blinks it after a hit and
// tracks remaining lives. Visibility only changes on a frame pulse so the
// border never tears mid-frame.
module border_flash_ctrl #(
  parameter int unsigned V_ACTIVE     = border_flash_ctrl_pkg::V_ACTIVE,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned FLASH_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Horizontal,
  input  logic [15:0] Vertical,
  input  logic        GreenWall,
  input  logic        go,
  input  logic        hit,
  output logic        border_on,
  output logic        frame_tick,
  output logic        playing,
  output logic        game_over,
  output logic [3:0]  lives
);

  import border_flash_ctrl_pkg::*;

  logic [1:0] state,     state_nx;
  logic [3:0] lives_q,   lives_nx;
  logic [7:0] frame_cnt, frame_cnt_nx;
  logic [7:0] blink_cnt, blink_cnt_nx;
  logic [7:0] blink_inc;
  logic       wall_vis,  wall_vis_nx;

  frame_tick_gen #(
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .Horizontal (Horizontal),
    .Vertical   (Vertical),
    .frame_tick (frame_tick)
  );

  // Zero-latency gating of the raw border pixel.
  always_comb begin
    border_on = GreenWall & wall_vis;
  end

  assign lives = lives_q;

  // Next-state logic for the game phase, counters and border visibility.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx     = state;
    lives_nx     = lives_q;
    frame_cnt_nx = frame_cnt;
    blink_cnt_nx = blink_cnt;
    wall_vis_nx  = wall_vis;
    blink_inc    = blink_cnt + 8'd1;

    case (state)
      IDLE: begin
        if (frame_tick) wall_vis_nx = 1'b1;
        // go takes priority; a simultaneous hit is simply dropped here.
        if (go) state_nx = PLAY;
      end

      PLAY: begin
        if (hit) begin
          // A tick arriving with the hit is swallowed: counters restart.
          state_nx     = FLASH;
          lives_nx     = sat_dec(lives_q);
          frame_cnt_nx = 8'd0;
          blink_cnt_nx = 8'd0;
        end else if (frame_tick) begin
          wall_vis_nx = 1'b1;
        end
      end

      FLASH: begin
        if (frame_tick) begin
          frame_cnt_nx = frame_cnt + 8'd1;
          if (blink_inc == 8'(BLINK_FRAMES)) begin
            blink_cnt_nx = 8'd0;
            wall_vis_nx  = ~wall_vis;
          end else begin
            blink_cnt_nx = blink_inc;
          end
          if (frame_cnt_nx == 8'(FLASH_FRAMES)) begin
            if (lives_q == 4'd0) begin
              state_nx = OVER;
            end else begin
              state_nx    = PLAY;
              wall_vis_nx = 1'b1;
            end
          end
        end
      end

      OVER: begin
        if (frame_tick) wall_vis_nx = 1'b0;
        if (go) begin
          state_nx = IDLE;
          lives_nx = 4'(LIVES);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // State, counter and decoded-status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lives_q   <= 4'(LIVES);
      frame_cnt <= 8'd0;
      blink_cnt <= 8'd0;
      wall_vis  <= 1'b1;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      lives_q   <= lives_nx;
      frame_cnt <= frame_cnt_nx;
      blink_cnt <= blink_cnt_nx;
      wall_vis  <= wall_vis_nx;
      playing   <= (state_nx == PLAY);
      game_over <= (state_nx == OVER);
    end
  end

endmodule

// File: doc/border_flash_ctrl.md
Name: border_flash_ctrl

Overview:
- Sequences display of the green playfield border for the VGA game.
- Takes the raw border-pixel flag and the pixel counters, and runs a small game-phase state machine: idle, play, hit-flash and game-over.
- Decides frame-by-frame whether the border is drawn, solid or blinking, and tracks remaining lives.
- Sits between the border generator and the pixel colour mux.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame; Vertical == V_ACTIVE is the first blanking line.
- LIVES, 3, lives loaded at reset and on restart; range 1..15.
- FLASH_FRAMES, 120, frames spent in FLASH after a hit; range 1..255.
- BLINK_FRAMES, 8, frames per blink half-period while flashing; range 1..255.

Ports:
- clk, input, 1, system pixel clock.
- reset, input, 1, synchronous, active-high.
- Horizontal, input, 16, current pixel column counter.
- Vertical, input, 16, current line counter.
- GreenWall, input, 1, raw border-pixel flag for the current pixel.
- go, input, 1, start/restart request, level, sampled each clk.
- hit, input, 1, collision strobe, sampled each clk.
- border_on, output, 1, gated border pixel to the colour mux.
- frame_tick, output, 1, one-clk pulse once per frame.
- playing, output, 1, high in PLAY.
- game_over, output, 1, high in OVER.
- lives, output, 4, remaining lives.

Behaviour:
- Reset values:
  - state = IDLE, lives = LIVES, wall_vis = 1.
  - frame_tick = 0, frame counter = 0, blink counter = 0.
  - playing = 0, game_over = 0.
- frame_tick:
  - frame_cond = (Horizontal == 0) & (Vertical == V_ACTIVE).
  - frame_tick is registered and asserts for exactly one clk, the cycle after frame_cond first goes high.
  - It fires on the rising edge of frame_cond (edge-detected), so a stalled counter never produces a repeat tick.
- border_on:
  - border_on = GreenWall & wall_vis, combinational; zero latency to the pixel.
  - wall_vis is a register that changes only on a frame_tick cycle, so the border never tears mid-frame.
- States and transitions:
  - IDLE: wall_vis -> 1. go -> PLAY.
  - PLAY: wall_vis -> 1.
    - hit -> FLASH; on that same cycle lives decrements by 1 (saturating at 0), and the frame and blink counters clear.
    - go is ignored.
  - FLASH: hit and go are ignored. On each frame_tick:
    - The frame counter increments.
    - The blink counter increments; when it reaches BLINK_FRAMES it clears and wall_vis toggles.
    - When the frame counter reaches FLASH_FRAMES: go to OVER if lives == 0, otherwise go to PLAY with wall_vis = 1.
  - OVER: wall_vis -> 0 at the next frame_tick. go -> IDLE with lives reloaded to LIVES.
- The FLASH entry update of wall_vis is applied at the first frame_tick inside FLASH.
- playing and game_over are registered decodes of state.
- Simultaneous events:
  - go and hit together in IDLE: go wins, hit is dropped.
  - hit is ignored in IDLE, FLASH and OVER; there is no queuing.
  - hit in PLAY on a frame_tick cycle: the transition to FLASH takes effect and that tick does not count toward FLASH_FRAMES.
- reset mid-FLASH or mid-frame returns all state to reset values on the next edge; frame_tick restarts from the edge detector.
- Counter widths:
  - frame and blink counters are 8 bits; no wrap within the parameter range.
  - lives is 4 bits, saturating.

Decomposition:
- Shared package:
  - game-state encoding: IDLE = 2'd0, PLAY = 2'd1, FLASH = 2'd2, OVER = 2'd3;
  - H_ACTIVE and V_ACTIVE constants, reused by the VGA sync and border blocks.
- One sub-module is natural: frame_tick_gen, which holds the frame_cond decode and the edge-detect register.
- The FSM, counters and gating live in border_flash_ctrl.

Test Plan:
- Counters driven through a full frame with V_ACTIVE = 480 -> exactly one frame_tick, one clk after Horizontal = 0, Vertical = 480.
- Counters held stalled at that point for 10 clks -> still exactly one tick.
- reset, then GreenWall = 1 -> border_on = 1, lives = 4'd3, state IDLE.
- go = 1 for one clk -> playing = 1 next cycle.
- go and hit together in IDLE -> go wins; playing = 1, lives = 3.
- FLASH_FRAMES = 4, BLINK_FRAMES = 1, hit in PLAY:
  - lives = 2 the next clk;
  - wall_vis pattern over frame_ticks 1..4 is 0, 1, 0, 1;
  - then playing = 1 and border_on follows GreenWall.
- Three hits in total, each after returning to PLAY, with FLASH_FRAMES = 4:
  - after the third flash, game_over = 1, lives = 0, and border_on = 0 from the next frame_tick;
  - go then gives IDLE with lives = 3.
- hit pulses during FLASH and OVER -> lives unchanged, state unchanged.
- reset asserted at the second flash frame -> next clk IDLE, lives = 3, border_on = GreenWall.
